// File: rtl/sar_search_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sar_search_ctrl_pkg
// Shared definitions for the successive-approximation search controller:
//   - state_t     : FSM state encoding (IDLE, EVAL, DONE)
//   - FLAG_*      : comparator flag vector encoding, ordered {gt, eq, lt}
//   - idx_width() : width of the bit-index register for a given operand width
// ---------------------------------------------------------------------------
package sar_search_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Legal (one-hot) comparator responses, vector ordered {gt, eq, lt}.
    localparam logic [2:0] FLAG_GT = 3'b100;
    localparam logic [2:0] FLAG_EQ = 3'b010;
    localparam logic [2:0] FLAG_LT = 3'b001;

    // A 1-bit operand still needs a 1-bit index register.
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// ---------------------------------------------------------------------------
// sar_search_ctrl
// Successive-approximation search controller. Drives the B operand of an
// external combinational magnitude comparator with a registered trial value
// and resolves the unknown A operand MSB first in at most WIDTH EVAL cycles.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous reset, active-high
//   start   in   1      search request, sampled only in IDLE
//   cmp_eq  in   1      comparator A == B
//   cmp_gt  in   1      comparator A >  B
//   cmp_lt  in   1      comparator A <  B
//   guess   out  WIDTH  registered trial value, drives comparator B
//   busy    out  1      high while evaluating
//   done    out  1      one-cycle pulse when a search ends
//   result  out  WIDTH  resolved value, held until the next accepted start
//   exact   out  1      an A == B response was seen, held like result
//   err     out  1      a non-one-hot flag response was seen, held like result
// ---------------------------------------------------------------------------
module sar_search_ctrl
    import sar_search_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    input  logic             cmp_lt,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             err
);

    localparam int IDX_W = idx_width(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_guess;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_result;
    logic               r_exact;
    logic               r_err;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_guess_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [WIDTH-1:0]   w_result_nxt;
    logic               w_exact_nxt;
    logic               w_err_nxt;

    logic [2:0]         w_flags;
    logic [WIDTH-1:0]   w_cur_mask;
    logic [WIDTH-1:0]   w_next_mask;
    logic [WIDTH-1:0]   w_kept;

    assign w_flags     = {cmp_gt, cmp_eq, cmp_lt};
    assign w_cur_mask  = WIDTH'(1) << r_idx;
    // Only consumed when r_idx != 0, so the wrap at r_idx == 0 is harmless.
    assign w_next_mask = WIDTH'(1) << (r_idx - IDX_W'(1));
    // A > guess keeps the trial bit; A < guess drops it.
    assign w_kept      = (w_flags == FLAG_LT) ? (r_guess & ~w_cur_mask) : r_guess;

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_state_nxt  = r_state;
        w_guess_nxt  = r_guess;
        w_idx_nxt    = r_idx;
        w_result_nxt = r_result;
        w_exact_nxt  = r_exact;
        w_err_nxt    = r_err;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_guess_nxt  = WIDTH'(1) << (WIDTH - 1);
                    w_idx_nxt    = IDX_W'(WIDTH - 1);
                    w_result_nxt = '0;
                    w_exact_nxt  = 1'b0;
                    w_err_nxt    = 1'b0;
                    w_state_nxt  = ST_EVAL;
                end
            end

            ST_EVAL: begin
                case (w_flags)
                    FLAG_EQ: begin
                        // Early exit: the current trial already matches A.
                        w_result_nxt = r_guess;
                        w_exact_nxt  = 1'b1;
                        w_state_nxt  = ST_DONE;
                    end
                    FLAG_GT, FLAG_LT: begin
                        if (r_idx == '0) begin
                            w_guess_nxt  = w_kept;
                            w_result_nxt = w_kept;
                            w_state_nxt  = ST_DONE;
                        end else begin
                            w_guess_nxt = w_kept | w_next_mask;
                            w_idx_nxt   = r_idx - IDX_W'(1);
                        end
                    end
                    default: begin
                        // No flag or several flags: comparator is misbehaving.
                        w_err_nxt    = 1'b1;
                        w_result_nxt = r_guess;
                        w_state_nxt  = ST_DONE;
                    end
                endcase
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_guess  <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_exact  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_guess  <= w_guess_nxt;
            r_idx    <= w_idx_nxt;
            r_result <= w_result_nxt;
            r_exact  <= w_exact_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign guess  = r_guess;
    assign busy   = (r_state == ST_EVAL);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;
    assign exact  = r_exact;
    assign err    = r_err;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sar_search_ctrl
// Self-checking bench for sar_search_ctrl (WIDTH = 4). A behavioural 4-bit
// magnitude comparator closes the loop (A from the bench, B = guess) and can
// be bypassed to force arbitrary flag vectors. Expected trial sequences and
// final results are pushed to queues when a search is started and popped as
// the DUT evaluates and reports done.
// ---------------------------------------------------------------------------
module tb_sar_search_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         cmp_eq;
    logic         cmp_gt;
    logic         cmp_lt;
    logic [W-1:0] guess;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         exact;
    logic         err;

    logic [W-1:0] a_val;
    logic         force_en;
    logic [2:0]   force_flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] result;
        logic         exact;
        logic         err;
        int           evals;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] guess_q[$];

    always #5 clk = ~clk;

    // Magnitude comparator with a bypass for injecting illegal flag vectors.
    assign {cmp_gt, cmp_eq, cmp_lt} = force_en ? force_flags
                                               : {a_val > guess, a_val == guess, a_val < guess};

    sar_search_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp_eq (cmp_eq),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .guess  (guess),
        .busy   (busy),
        .done   (done),
        .result (result),
        .exact  (exact),
        .err    (err)
    );

    // Reference: trial k keeps A's bits above position W-1-k and sets that
    // position; the search stops at the first trial equal to A.
    task automatic push_model(input logic [W-1:0] a);
        exp_t e;
        int   n = 0;
        int   ai = int'(a);
        for (int k = 0; k < W; k++) begin
            int pos = W - 1 - k;
            int hi  = (ai >> (pos + 1)) << (pos + 1);
            int g   = hi | (1 << pos);
            guess_q.push_back(W'(g));
            n++;
            if (g == ai) break;
        end
        e.result = a;
        e.exact  = (a != '0);
        e.err    = 1'b0;
        e.evals  = n;
        exp_q.push_back(e);
    endtask

    task automatic run_search(input logic [W-1:0] a, input bit do_force,
                              input logic [2:0] ff, input int restart_at,
                              input bit poke_done);
        exp_t         e;
        int           evals;
        bit           got;
        logic [W-1:0] g_exp;

        @(negedge clk);
        a_val       = a;
        force_en    = do_force;
        force_flags = ff;
        start       = 1'b1;
        if (do_force) begin
            guess_q.push_back(W'(1 << (W - 1)));
            e.result = W'(1 << (W - 1));
            e.exact  = 1'b0;
            e.err    = 1'b1;
            e.evals  = 1;
            exp_q.push_back(e);
        end else begin
            push_model(a);
        end
        @(negedge clk);
        start = 1'b0;

        evals = 0;
        got   = 1'b0;
        for (int cyc = 0; cyc < 2 * W + 4 && !got; cyc++) begin
            if (done) begin
                got   = 1'b1;
                start = poke_done;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected a=%b: done with no pending search", a);
                end else begin
                    e = exp_q.pop_front();
                    if ({result, exact, err} !== {e.result, e.exact, e.err})
                        begin
                        errors++;
                        $display("FAIL result a=%b: got result=%b exact=%b err=%b, want result=%b exact=%b err=%b",
                                 a, result, exact, err, e.result, e.exact, e.err);
                    end
                    checks++;
                    if (evals !== e.evals) begin
                        errors++;
                        $display("FAIL eval_count a=%b: got %0d, want %0d", a, evals, e.evals);
                    end
                end
                checks++;
                if (busy !== 1'b0 || guess_q.size() != 0) begin
                    errors++;
                    $display("FAIL done_state a=%b: busy=%b, %0d expected trials unused",
                             a, busy, guess_q.size());
                end
                @(negedge clk);
                start = 1'b0;
                checks++;
                if ({done, busy} !== 2'b00) begin
                    errors++;
                    $display("FAIL after_done a=%b: got done=%b busy=%b, want 0 0", a, done, busy);
                end
            end else if (busy) begin
                evals++;
                checks++;
                if (guess_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_eval a=%b: guess=%b beyond expected trials", a, guess);
                end else begin
                    g_exp = guess_q.pop_front();
                    if (guess !== g_exp) begin
                        errors++;
                        $display("FAIL guess a=%b eval %0d: got %b, want %b", a, evals, guess, g_exp);
                    end
                end
                start = (evals == restart_at);
                @(negedge clk);
            end else begin
                checks++;
                errors++;
                $display("FAIL not_busy a=%b: got busy=%b done=%b, want busy=1", a, busy, done);
                @(negedge clk);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout a=%b: done never seen", a);
        end
        start    = 1'b0;
        force_en = 1'b0;
        guess_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        start       = 1'b0;
        a_val       = '0;
        force_en    = 1'b0;
        force_flags = 3'b000;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, exact, err, guess, result} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b exact=%b err=%b guess=%b result=%b, want all 0",
                     busy, done, exact, err, guess, result);
        end
        // rst and start together: reset wins.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        checks++;
        if ({busy, guess} !== '0) begin
            errors++;
            $display("FAIL reset_beats_start: got busy=%b guess=%b, want 0 0000", busy, guess);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_search();
        run_search(4'b1011, 1'b0, 3'b000, 0, 1'b0);
        run_search(4'b1000, 1'b0, 3'b000, 0, 1'b0);
        run_search(4'b0000, 1'b0, 3'b000, 0, 1'b0);
        run_search(4'b1111, 1'b0, 3'b000, 0, 1'b0);
        run_search(4'b0110, 1'b0, 3'b000, 0, 1'b0);
        run_search(4'b0001, 1'b0, 3'b000, 0, 1'b0);
    endtask

    task automatic test_bad_flags();
        run_search(4'b0101, 1'b1, 3'b000, 0, 1'b0);
        run_search(4'b0101, 1'b1, 3'b110, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        // Second start during the 2nd EVAL, and another in the DONE cycle.
        run_search(4'b0101, 1'b0, 3'b000, 2, 1'b1);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        a_val = 4'b0110;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, guess} !== {1'b1, 4'b0100}) begin
            errors++;
            $display("FAIL mid_second_eval: got busy=%b guess=%b, want 1 0100", busy, guess);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, exact, err, guess, result} !== '0) begin
            errors++;
            $display("FAIL mid_reset_state: got busy=%b done=%b exact=%b err=%b guess=%b result=%b, want all 0",
                     busy, done, exact, err, guess, result);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({done, busy} !== 2'b00) begin
                errors++;
                $display("FAIL mid_reset_quiet cycle %0d: got done=%b busy=%b, want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_search(4'b0110, 1'b0, 3'b000, 0, 1'b0);
        run_search(4'b1001, 1'b0, 3'b000, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_search();
        test_bad_flags();
        test_start_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
